// File: rtl/div_clk_meter_if.sv
// Divided-clock meter bus: the sampled divided clock and
// enable in, period/high-time results and stuck flags out.
interface div_clk_meter_if #(
  parameter int CNT_W = 16
) ();
  logic             clk_div_in;
  logic             en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output clk_div_in,
    output en,
    input  period,
    input  high_time,
    input  meas_valid,
    input  stuck,
    input  stuck_level
  );

  modport slave (
    input  clk_div_in,
    input  en,
    output period,
    output high_time,
    output meas_valid,
    output stuck,
    output stuck_level
  );
endinterface

// File: rtl/div_clk_meter.sv
// Measures period/high time of the divided clock in clk cycles.
// Ports: clk, rst_n (async low), m (slave side of meter bus).
module div_clk_meter #(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic           clk,
  input  logic           rst_n,
  div_clk_meter_if.slave m
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    STUCK
  } state_t;

  state_t state_q, state_d;

  logic s1, s2, s_prev;
  logic rise, fall;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             level_q, level_d;

  // s1/s2 resolve metastability; s_prev gives one-cycle edges
  assign rise = s2 & ~s_prev;
  assign fall = ~s2 & s_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s1     <= m.clk_div_in;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_cap_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_cap_q <= high_cap_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      stuck_q    <= stuck_d;
      level_q    <= level_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_cap_d = high_cap_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    stuck_d    = stuck_q;
    level_d    = level_q;

    if (!m.en) begin
      // disable beats any edge in the same cycle
      state_d = IDLE;
      stuck_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
        end
        ARM: begin
          // first rise only opens the window
          if (rise) begin
            cnt_d   = ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (fall) high_cap_d = cnt_q;
          // a rise at cnt==TMO is a valid result
          if (rise) begin
            period_d = cnt_q;
            high_d   = high_cap_q;
            valid_d  = 1'b1;
            cnt_d    = ONE;
          end else if (cnt_q == TMO) begin
            state_d  = STUCK;
            stuck_d  = 1'b1;
            level_d  = s2;
            period_d = '0;
            high_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        STUCK: begin
          if (rise) begin
            stuck_d = 1'b0;
            cnt_d   = ONE;
            state_d = MEASURE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign m.period      = period_q;
  assign m.high_time   = high_q;
  assign m.meas_valid  = valid_q;
  assign m.stuck       = stuck_q;
  assign m.stuck_level = level_q;

endmodule

// File: tb/tb_div_clk_meter.sv
// Scoreboard bench for div_clk_meter (TIMEOUT=100).
// Expected results are queued as each period is driven.
module tb_div_clk_meter;

  typedef struct {
    logic [15:0] p;
    logic [15:0] h;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   n_valid;
  exp_t sb[$];

  div_clk_meter_if #(.CNT_W(16)) dut_if ();

  div_clk_meter #(
    .CNT_W  (16),
    .TIMEOUT(100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .m    (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && dut_if.meas_valid) begin
      n_valid++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid period=%0d",
                 dut_if.period);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dut_if.period !== e.p) begin
          errors++;
          $display("FAIL period got=%0d exp=%0d",
                   dut_if.period, e.p);
        end
        checks++;
        if (dut_if.high_time !== e.h) begin
          errors++;
          $display("FAIL high_time got=%0d exp=%0d",
                   dut_if.high_time, e.h);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive_period(input int p, input int h,
                              input bit push);
    exp_t e;
    e.p = 16'(p);
    e.h = 16'(h);
    if (push) sb.push_back(e);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      dut_if.clk_div_in = (i < h);
    end
  endtask

  task automatic close_rise();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dut_if.clk_div_in = 1'b1;
    end
    @(negedge clk);
    dut_if.clk_div_in = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d exp=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic arm();
    @(negedge clk);
    dut_if.en = 1'b1;
    wait_cyc(2);
  endtask

  task automatic go_idle();
    @(negedge clk);
    dut_if.en = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dut_if.en = 1'b0;
    dut_if.clk_div_in = 1'b0;
    wait_cyc(3);
    checks++;
    if ({dut_if.period, dut_if.high_time, dut_if.meas_valid,
         dut_if.stuck, dut_if.stuck_level} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {dut_if.period, dut_if.high_time});
    end
    rst_n = 1'b1;
    wait_cyc(2);
    checks++;
    if (dut_if.meas_valid !== 1'b0 || dut_if.stuck !== 1'b0) begin
      errors++;
      $display("FAIL post_reset valid=%b stuck=%b exp=0 0",
               dut_if.meas_valid, dut_if.stuck);
    end
  endtask

  task automatic test_div2();
    int nv;
    arm();
    nv = n_valid;
    for (int i = 0; i < 10; i++) drive_period(2, 1, 1'b1);
    close_rise();
    checks++;
    if (n_valid - nv != 10) begin
      errors++;
      $display("FAIL div2_count got=%0d exp=10", n_valid - nv);
    end
    go_idle();
  endtask

  task automatic test_duty();
    arm();
    for (int i = 0; i < 4; i++) drive_period(10, 5, 1'b1);
    for (int i = 0; i < 3; i++) drive_period(10, 3, 1'b1);
    close_rise();
    go_idle();
  endtask

  task automatic test_stuck();
    arm();
    @(negedge clk);
    dut_if.clk_div_in = 1'b1;
    for (int i = 1; i <= 103; i++) begin
      @(negedge clk);
      if (i == 1) dut_if.clk_div_in = 1'b0;
      if (i == 102) begin
        checks++;
        if (dut_if.stuck !== 1'b0 || dut_if.period !== 16'd10) begin
          errors++;
          $display("FAIL pre_stuck stuck=%b period=%0d exp=0 10",
                   dut_if.stuck, dut_if.period);
        end
      end
    end
    checks++;
    if (dut_if.stuck !== 1'b1 || dut_if.stuck_level !== 1'b0) begin
      errors++;
      $display("FAIL stuck stuck=%b level=%b exp=1 0",
               dut_if.stuck, dut_if.stuck_level);
    end
    checks++;
    if (dut_if.period !== 16'd0 || dut_if.high_time !== 16'd0) begin
      errors++;
      $display("FAIL stuck_clear period=%0d high=%0d exp=0 0",
               dut_if.period, dut_if.high_time);
    end
    drive_period(8, 4, 1'b1);
    checks++;
    if (dut_if.stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_release got=%b exp=0", dut_if.stuck);
    end
    drive_period(8, 4, 1'b1);
    drive_period(8, 4, 1'b1);
    close_rise();
    go_idle();
  endtask

  task automatic test_timeout_edge();
    arm();
    drive_period(100, 5, 1'b1);
    drive_period(100, 5, 1'b1);
    checks++;
    if (dut_if.stuck !== 1'b0) begin
      errors++;
      $display("FAIL edge_stuck got=%b exp=0", dut_if.stuck);
    end
    close_rise();
    checks++;
    if (dut_if.stuck !== 1'b0 || dut_if.period !== 16'd100) begin
      errors++;
      $display("FAIL edge_final stuck=%b period=%0d exp=0 100",
               dut_if.stuck, dut_if.period);
    end
    go_idle();
  endtask

  task automatic test_en_drop();
    int nv;
    arm();
    drive_period(10, 5, 1'b1);
    drive_period(10, 5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dut_if.clk_div_in = 1'b1;
    end
    @(negedge clk);
    dut_if.en = 1'b0;
    nv = n_valid;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dut_if.clk_div_in = 1'b0;
    end
    for (int i = 0; i < 3; i++) drive_period(10, 5, 1'b0);
    checks++;
    if (n_valid != nv || dut_if.period !== 16'd10) begin
      errors++;
      $display("FAIL en_off pulses=%0d period=%0d exp=0 10",
               n_valid - nv, dut_if.period);
    end
    checks++;
    if (dut_if.high_time !== 16'd5) begin
      errors++;
      $display("FAIL en_off_high got=%0d exp=5",
               dut_if.high_time);
    end
    arm();
    nv = n_valid;
    drive_period(10, 5, 1'b1);
    checks++;
    if (n_valid != nv) begin
      errors++;
      $display("FAIL rearm_first got=%0d exp=0", n_valid - nv);
    end
    drive_period(10, 5, 1'b1);
    close_rise();
    go_idle();
  endtask

  task automatic test_reset_async();
    arm();
    drive_period(10, 5, 1'b1);
    drive_period(10, 5, 1'b1);
    close_rise();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dut_if.period, dut_if.high_time, dut_if.meas_valid,
         dut_if.stuck, dut_if.stuck_level} !== 35'd0) begin
      errors++;
      $display("FAIL async_reset period=%0d high=%0d exp=0 0",
               dut_if.period, dut_if.high_time);
    end
    #1 rst_n = 1'b1;
    wait_cyc(2);
    drive_period(10, 5, 1'b1);
    drive_period(10, 5, 1'b1);
    close_rise();
    checks++;
    if (dut_if.period !== 16'd10) begin
      errors++;
      $display("FAIL resume period got=%0d exp=10", dut_if.period);
    end
    go_idle();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    n_valid = 0;
    test_reset();
    test_div2();
    test_duty();
    test_stuck();
    test_timeout_edge();
    test_en_drop();
    test_reset_async();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
